// File: rtl/edge_gen.sv
// edge_gen: programmable pulse-train generator.
//
// A single-cycle start in IDLE latches high_len/low_len/num_pulses. The block
// then emits num_pulses periods: wave is high for H cycles, then low for L
// cycles. A zero length is stretched to one cycle, so consecutive edges are
// always at least one cycle apart. The trailing low phase of the last pulse is
// always emitted. After it, done pulses for one cycle with busy already low.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        launch request, honoured only in IDLE and only without abort
//   abort        ends any burst; the next cycle is idle with wave low and no done
//   high_len     cycles high per pulse (0 acts as 1), latched on start
//   low_len      cycles low per pulse (0 acts as 1), latched on start
//   num_pulses   pulses per burst, latched on start
//   wave         generated waveform (flop)
//   busy         burst in progress (flop)
//   done         one-cycle pulse on normal completion (flop)
//   pulses_left  pulses not yet started (flop)
//
// Optional feature, macro EDGE_GEN_CONT_EN:
//   When defined, num_pulses=0 at start selects continuous mode. The train
//   repeats until abort or reset, pulses_left holds 0, and done never fires.
//   When undefined, num_pulses=0 produces an immediate done pulse.

module edge_gen #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [CNT_W-1:0] num_pulses,
   output logic             wave,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulses_left
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   // Latched phase lengths. They hold the effective (zero-stretched) values,
   // so a reload is always len-1.
   typedef struct packed {
      logic [CNT_W-1:0] hi;
      logic [CNT_W-1:0] lo;
   } cfg_t;

   state_t           state, state_nxt;
   cfg_t             cfg_q, cfg_nxt, cfg_in;
   logic [CNT_W-1:0] phase_cnt, phase_cnt_nxt;
   logic [CNT_W-1:0] pl_nxt;
   logic             wave_nxt, busy_nxt, done_nxt;
   logic             req;
`ifdef EDGE_GEN_CONT_EN
   logic             cont_q, cont_nxt;
`endif

   assign cfg_in.hi = (high_len == '0) ? CNT_W'(1) : high_len;
   assign cfg_in.lo = (low_len  == '0) ? CNT_W'(1) : low_len;

   // abort dominates start in every state
   assign req = start & ~abort;

   always_comb begin
      state_nxt     = state;
      cfg_nxt       = cfg_q;
      phase_cnt_nxt = phase_cnt;
      pl_nxt        = pulses_left;
      wave_nxt      = wave;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
`ifdef EDGE_GEN_CONT_EN
      cont_nxt      = cont_q;
`endif

      case (state)
         IDLE: begin
            if (req) begin
               if (num_pulses != '0) begin
                  cfg_nxt       = cfg_in;
                  phase_cnt_nxt = cfg_in.hi - CNT_W'(1);
                  pl_nxt        = num_pulses - CNT_W'(1);
                  wave_nxt      = 1'b1;
                  busy_nxt      = 1'b1;
                  state_nxt     = HIGH;
`ifdef EDGE_GEN_CONT_EN
                  cont_nxt      = 1'b0;
`endif
               end else begin
`ifdef EDGE_GEN_CONT_EN
                  cfg_nxt       = cfg_in;
                  phase_cnt_nxt = cfg_in.hi - CNT_W'(1);
                  pl_nxt        = '0;
                  wave_nxt      = 1'b1;
                  busy_nxt      = 1'b1;
                  state_nxt     = HIGH;
                  cont_nxt      = 1'b1;
`else
                  done_nxt      = 1'b1;
`endif
               end
            end
         end

         HIGH: begin
            if (phase_cnt == '0) begin
               phase_cnt_nxt = cfg_q.lo - CNT_W'(1);
               wave_nxt      = 1'b0;
               state_nxt     = LOW;
            end else begin
               phase_cnt_nxt = phase_cnt - CNT_W'(1);
            end
         end

         LOW: begin
            if (phase_cnt == '0) begin
`ifdef EDGE_GEN_CONT_EN
               if (pulses_left != '0 || cont_q) begin
`else
               if (pulses_left != '0) begin
`endif
                  phase_cnt_nxt = cfg_q.hi - CNT_W'(1);
                  // In continuous mode pulses_left is 0 and stays there.
                  if (pulses_left != '0)
                     pl_nxt = pulses_left - CNT_W'(1);
                  wave_nxt      = 1'b1;
                  state_nxt     = HIGH;
               end else begin
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
            end else begin
               phase_cnt_nxt = phase_cnt - CNT_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
            wave_nxt  = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase

      // Abort overrides the state transitions above. In IDLE all of these
      // signals are already zero.
      if (abort) begin
         state_nxt     = IDLE;
         phase_cnt_nxt = '0;
         pl_nxt        = '0;
         wave_nxt      = 1'b0;
         busy_nxt      = 1'b0;
         done_nxt      = 1'b0;
`ifdef EDGE_GEN_CONT_EN
         cont_nxt      = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cfg_q       <= '0;
         phase_cnt   <= '0;
         pulses_left <= '0;
         wave        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef EDGE_GEN_CONT_EN
         cont_q      <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         cfg_q       <= cfg_nxt;
         phase_cnt   <= phase_cnt_nxt;
         pulses_left <= pl_nxt;
         wave        <= wave_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
`ifdef EDGE_GEN_CONT_EN
         cont_q      <= cont_nxt;
`endif
      end
   end

endmodule

// File: doc/edge_gen.md
Name: edge_gen

Overview:
- Programmable pulse-train generator. It drives the waveform whose edges the rise/fall detectors consume.
- A single-cycle `start` launches N high/low periods with configured widths, producing clean rising and falling edges on a registered output.
- Used as a stimulus/strobe source feeding edge-detector inputs and external enable lines.

Parameters:
- CNT_W, 8, width of the length and pulse-count fields (max 2^CNT_W-1 cycles per phase / pulses per burst).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle launch request; sampled only in IDLE
- abort  input  1  terminate burst; wave forced low
- high_len  input  CNT_W  cycles wave is high per pulse; latched on accepted start
- low_len  input  CNT_W  cycles wave is low after each pulse; latched on accepted start
- num_pulses  input  CNT_W  pulses in burst; latched on accepted start
- wave  output  1  generated waveform, registered
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse on normal burst completion
- pulses_left  output  CNT_W  pulses not yet started, including none for the current one

Behaviour:
- Reset (async, rst_n=0):
  - wave=0, busy=0, done=0, pulses_left=0.
  - FSM=IDLE; latched config cleared.
  - Reset mid-burst aborts immediately with no done.
- FSM states are IDLE, HIGH, LOW. The phase counter counts down and the pulse counter counts down.
- Zero-width handling: high_len=0 is treated as 1 and low_len=0 is treated as 1, so every edge is at least one cycle apart.
- IDLE:
  - start=1 and abort=0 and num_pulses!=0 at edge t0:
    - Latch config; go to HIGH.
    - Registered outputs: wave=1 and busy=1 from cycle t0+1.
    - pulses_left=num_pulses-1.
  - start with num_pulses=0: no pulse; done=1 in cycle t0+1 only; busy stays 0; wave stays 0. This changes under EDGE_GEN_CONT_EN (see Optional Feature).
  - start and abort both high in IDLE: abort wins and start is ignored.
- HIGH:
  - wave=1 for exactly H cycles (t0+1..t0+H), where H is the effective high length.
  - Then go to LOW.
- LOW:
  - wave=0 for exactly L cycles, where L is the effective low length.
  - At the end of LOW with pulses_left!=0: go to HIGH and decrement pulses_left. The next rising edge is at cycle t0+k(H+L)+1.
  - At the end of LOW with pulses_left==0: go to IDLE. In cycle t0+N(H+L)+1, busy=0 and done=1 for one cycle.
  - The trailing low phase is always emitted.
- Burst timing: total busy duration is N(H+L) cycles.
- start while busy: ignored, with no effect on the config or counters.
- Config inputs changing mid-burst: no effect; only the values latched at start are used.
- abort while busy, sampled at edge ta:
  - In cycle ta+1: wave=0, busy=0, pulses_left=0, FSM=IDLE, done=0.
  - start at ta+1 is accepted normally.
- done and busy are never high in the same cycle.
- All outputs are driven directly from flops, with no combinational paths from inputs.

Optional Feature:
- Macro: EDGE_GEN_CONT_EN.
- Defined:
  - num_pulses=0 at start selects continuous mode.
  - The H/L train repeats indefinitely; busy=1 and pulses_left holds 0.
  - done is never asserted in this mode; it ends only via abort or reset.
- Undefined: num_pulses=0 gives the immediate done described in Behaviour. No continuous logic is present.

Test Plan:
- Basic burst:
  - Stimulus: reset, then start with high_len=3, low_len=2, num_pulses=2 at t0.
  - Response: wave=1 in t0+1..t0+3, 0 in t0+4..t0+5, 1 in t0+6..t0+8, 0 in t0+9..t0+10.
  - Response: done=1 only in t0+11, where busy=0; pulses_left=1 then 0.
- Zero-length handling:
  - Stimulus: high_len=0, low_len=0, num_pulses=3.
  - Response: wave alternates 1,0,1,0,1,0 over t0+1..t0+6; done in t0+7.
- num_pulses=0 (macro undefined):
  - Response: done=1 in t0+1; wave and busy stay 0.
  - With EDGE_GEN_CONT_EN defined: wave toggles H/L indefinitely for 100+ cycles with no done; abort returns wave and busy to 0 next cycle.
- abort and start handling:
  - Stimulus: abort during the 2nd HIGH phase of a 5-pulse burst.
  - Response: wave=0 and busy=0 next cycle, no done.
  - Stimulus: start while busy, with different config.
  - Response: ignored; the original timing is unchanged.
  - Stimulus: start and abort asserted together in IDLE.
  - Response: no burst starts.
- Async reset mid-LOW:
  - Stimulus: assert rst_n=0 between clock edges.
  - Response: all outputs 0 immediately.
  - Stimulus: release reset, then start with high_len=1, low_len=1, num_pulses=1.
  - Response: wave=1 in t0+1, done in t0+3.
